// File: rtl/cache_def.sv
// Cache-side memory interface types shared by the cache controllers and the
// memory arbiter, plus the arbiter's state encoding.
package cache_def;
  localparam int ADDR_WIDTH  = 32;
  localparam int DATA_WIDTH  = 128;
  localparam int NUM_MEM_REQ = 2;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  rw;
    logic                  valid;
  } mem_req_type;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;
  } mem_data_type;

  typedef enum logic [1:0] {ARB_IDLE, ARB_MEM, ARB_RESP} arb_state_e;
endpackage

// File: rtl/cache_mem_arbiter_rr2.sv
// Two-way requester picker: round-robin against the last grant, or fixed
// priority to port 1. The last-grant register advances only when a pick is taken.
module arb_rr2 import cache_def::*; #(
  parameter int PRIO_MODE = 0
) (
  input  logic                   gclk,
  input  logic                   grst_n,
  input  logic [NUM_MEM_REQ-1:0] req_i,
  input  logic                   take_i,
  output logic                   gnt_o
);
  logic last_grant;

  always_comb begin
    gnt_o = 1'b0;
    if (PRIO_MODE == 1)
      gnt_o = req_i[1];
    else if (req_i[~last_grant])
      gnt_o = ~last_grant;
    else
      gnt_o = req_i[1];
  end

  // Reset to port 1 so the first round-robin decision favours port 0.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)
      last_grant <= 1'b1;
    else if (take_i)
      last_grant <= gnt_o;
  end
endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the line-wide memory port between the I-cache (port 0) and the
// D-cache (port 1); one transaction at a time, request held in registers.
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = cache_def::DATA_WIDTH,
  parameter int OFFSET_BITS = 4,
  parameter int PRIO_MODE   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  r0_valid_i,
  input  logic                  r0_rw_i,
  input  logic [ADDR_WIDTH-1:0] r0_addr_i,
  input  logic [DATA_WIDTH-1:0] r0_wdata_i,
  output logic                  r0_ready_o,
  output logic [DATA_WIDTH-1:0] r0_rdata_o,
  input  logic                  r1_valid_i,
  input  logic                  r1_rw_i,
  input  logic [ADDR_WIDTH-1:0] r1_addr_i,
  input  logic [DATA_WIDTH-1:0] r1_wdata_i,
  output logic                  r1_ready_o,
  output logic [DATA_WIDTH-1:0] r1_rdata_o,
  output logic                  mem_valid_o,
  output logic                  mem_rw_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  grant_o
);
  localparam int NREQ = cache_def::NUM_MEM_REQ;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

  // Same field order as cache_def::mem_req_type, sized by this instance.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  rw;
  } req_t;

  cache_def::arb_state_e           state;
  logic [NREQ-1:0]                 req_vld;
  req_t [NREQ-1:0]                 req_in;
  req_t                            req_q;
  logic                            owner;
  logic                            pick;
  logic                            take;
  logic [NREQ-1:0]                 ready_q;
  logic [DATA_WIDTH-1:0]           rdata_q;
  logic [NREQ-1:0][DATA_WIDTH-1:0] rdata_port;

  assign req_vld   = {r1_valid_i, r0_valid_i};
  assign req_in[0] = {r0_addr_i, r0_wdata_i, r0_rw_i};
  assign req_in[1] = {r1_addr_i, r1_wdata_i, r1_rw_i};
  assign take      = (state == cache_def::ARB_IDLE) && (|req_vld);

  arb_rr2 #(.PRIO_MODE(PRIO_MODE)) u_pick (
    .gclk   (clk_i),
    .grst_n (rst_ni),
    .req_i  (req_vld),
    .take_i (take),
    .gnt_o  (pick)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= cache_def::ARB_IDLE;
      owner       <= 1'b0;
      req_q       <= '0;
      rdata_q     <= '0;
      ready_q     <= '0;
      mem_valid_o <= 1'b0;
    end else begin
      case (state)
        cache_def::ARB_IDLE: begin
          if (take) begin
            owner       <= pick;
            req_q       <= req_in[pick];
            mem_valid_o <= 1'b1;
            state       <= cache_def::ARB_MEM;
          end
        end
        cache_def::ARB_MEM: begin
          if (mem_ready_i) begin
            mem_valid_o    <= 1'b0;
            ready_q[owner] <= 1'b1;
            rdata_q        <= req_q.rw ? '0 : mem_rdata_i;
            state          <= cache_def::ARB_RESP;
          end
        end
        cache_def::ARB_RESP: begin
          ready_q <= '0;
          rdata_q <= '0;
          state   <= cache_def::ARB_IDLE;
        end
        default: state <= cache_def::ARB_IDLE;
      endcase
    end
  end

  // The captured line is shared; only the owner's port ever sees it.
  for (genvar p = 0; p < NREQ; p++) begin : g_port
    assign rdata_port[p] = ready_q[p] ? rdata_q : '0;
  end

  assign r0_ready_o  = ready_q[0];
  assign r1_ready_o  = ready_q[1];
  assign r0_rdata_o  = rdata_port[0];
  assign r1_rdata_o  = rdata_port[1];
  assign mem_rw_o    = req_q.rw;
  assign mem_addr_o  = req_q.addr & LINE_MASK;
  assign mem_wdata_o = req_q.data;
  assign grant_o     = owner;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: one round-robin and one fixed-priority instance,
// directed scenarios then random traffic checked against a transaction model.
module tb_cache_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // index [d] selects the instance: 0 = round-robin, 1 = fixed priority
  logic          rv    [2][2];
  logic          rrw   [2][2];
  logic [AW-1:0] raddr [2][2];
  logic [DW-1:0] rwd   [2][2];
  logic          mrdy  [2];
  logic [DW-1:0] mrd   [2];
  logic          o_rdy [2][2];
  logic [DW-1:0] o_rd  [2][2];
  logic          o_mv  [2];
  logic          o_mrw [2];
  logic [AW-1:0] o_ma  [2];
  logic [DW-1:0] o_mwd [2];
  logic          o_gnt [2];

  cache_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OFFSET_BITS(4), .PRIO_MODE(0)) u_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .r0_valid_i(rv[0][0]), .r0_rw_i(rrw[0][0]), .r0_addr_i(raddr[0][0]), .r0_wdata_i(rwd[0][0]),
    .r0_ready_o(o_rdy[0][0]), .r0_rdata_o(o_rd[0][0]),
    .r1_valid_i(rv[0][1]), .r1_rw_i(rrw[0][1]), .r1_addr_i(raddr[0][1]), .r1_wdata_i(rwd[0][1]),
    .r1_ready_o(o_rdy[0][1]), .r1_rdata_o(o_rd[0][1]),
    .mem_valid_o(o_mv[0]), .mem_rw_o(o_mrw[0]), .mem_addr_o(o_ma[0]), .mem_wdata_o(o_mwd[0]),
    .mem_ready_i(mrdy[0]), .mem_rdata_i(mrd[0]), .grant_o(o_gnt[0]));

  cache_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OFFSET_BITS(4), .PRIO_MODE(1)) u_pr (
    .clk_i(clk), .rst_ni(rst_n),
    .r0_valid_i(rv[1][0]), .r0_rw_i(rrw[1][0]), .r0_addr_i(raddr[1][0]), .r0_wdata_i(rwd[1][0]),
    .r0_ready_o(o_rdy[1][0]), .r0_rdata_o(o_rd[1][0]),
    .r1_valid_i(rv[1][1]), .r1_rw_i(rrw[1][1]), .r1_addr_i(raddr[1][1]), .r1_wdata_i(rwd[1][1]),
    .r1_ready_o(o_rdy[1][1]), .r1_rdata_o(o_rd[1][1]),
    .mem_valid_o(o_mv[1]), .mem_rw_o(o_mrw[1]), .mem_addr_o(o_ma[1]), .mem_wdata_o(o_mwd[1]),
    .mem_ready_i(mrdy[1]), .mem_rdata_i(mrd[1]), .grant_o(o_gnt[1]));

  int checks = 0;
  int failures = 0;

  // model: outstanding requests per port and the last winner per instance
  bit pend  [2][2];
  int mlast [2];

  logic          seen_gnt;
  logic [AW-1:0] seen_addr;
  logic [DW-1:0] seen_rdata;

  task automatic check_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_d(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic raise(input int d, input int p, input logic rw, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    rv[d][p]    = 1'b1;
    rrw[d][p]   = rw;
    raddr[d][p] = a;
    rwd[d][p]   = wd;
    pend[d][p]  = 1'b1;
  endtask

  task automatic clear_all();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        rv[d][p] = 1'b0; rrw[d][p] = 1'b0; raddr[d][p] = '0; rwd[d][p] = '0;
        pend[d][p] = 1'b0;
      end
      mrdy[d]  = 1'b0;
      mrd[d]   = '0;
      mlast[d] = 1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_all();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Winner rule: fixed-priority instance prefers port 1; round-robin prefers
  // whichever port did not win last time; a lone requester always wins.
  function automatic int model_pick(input int d);
    if (pend[d][0] && pend[d][1])
      return (d == 1) ? 1 : 1 - mlast[d];
    return pend[d][1] ? 1 : 0;
  endfunction

  task automatic check_quiet(input int d, input string tag);
    for (int p = 0; p < 2; p++) begin
      check_b($sformatf("%s_ready%0d_d%0d", tag, p, d), o_rdy[d][p], 1'b0);
      check_d($sformatf("%s_rdata%0d_d%0d", tag, p, d), o_rd[d][p], '0);
    end
  endtask

  task automatic check_mem(input int d, input string tag, input logic rw,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic g);
    check_b($sformatf("%s_mem_valid_d%0d", tag, d), o_mv[d], 1'b1);
    check_b($sformatf("%s_mem_rw_d%0d", tag, d), o_mrw[d], rw);
    check_a($sformatf("%s_mem_addr_d%0d", tag, d), o_ma[d], a);
    check_d($sformatf("%s_mem_wdata_d%0d", tag, d), o_mwd[d], wd);
    check_b($sformatf("%s_grant_d%0d", tag, d), o_gnt[d], g);
  endtask

  // Called with the instance idle and about to sample its inputs; returns one
  // cycle after the ready pulse, which is where requesters may change inputs.
  task automatic serve(input int d, input int delay, input logic [DW-1:0] mdata,
                       input bit inject, output int win);
    int            w;
    int            n;
    logic          exp_rw;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_wd;
    w      = model_pick(d);
    exp_rw = rrw[d][w];
    exp_a  = raddr[d][w] & ~32'hF;
    exp_wd = rwd[d][w];
    mrdy[d] = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_mv[d] && n < 8);
    check_a($sformatf("req_to_mem_cycles_d%0d", d), AW'(n), AW'(1));
    check_mem(d, "grant", exp_rw, exp_a, exp_wd, w[0]);
    seen_gnt  = o_gnt[d];
    seen_addr = o_ma[d];
    if (inject && !pend[d][1-w])
      raise(d, 1 - w, 1'($urandom_range(0, 1)), $urandom(), rnd_line());
    for (int c = 0; c < delay; c++) begin
      tick();
      check_mem(d, "hold", exp_rw, exp_a, exp_wd, w[0]);
      check_quiet(d, "hold");
    end
    mrdy[d] = 1'b1;
    mrd[d]  = mdata;
    tick();
    // a stray memory ready while the response is out must be ignored
    mrdy[d] = 1'($urandom_range(0, 1));
    mrd[d]  = rnd_line();
    check_b($sformatf("resp_ready_owner_d%0d", d), o_rdy[d][w], 1'b1);
    check_d($sformatf("resp_rdata_owner_d%0d", d), o_rd[d][w], exp_rw ? '0 : mdata);
    check_b($sformatf("resp_ready_other_d%0d", d), o_rdy[d][1-w], 1'b0);
    check_d($sformatf("resp_rdata_other_d%0d", d), o_rd[d][1-w], '0);
    check_b($sformatf("resp_mem_valid_d%0d", d), o_mv[d], 1'b0);
    seen_rdata = o_rd[d][w];
    tick();
    mrdy[d] = 1'b0;
    check_quiet(d, "after_resp");
    rv[d][w]   = 1'b0;
    pend[d][w] = 1'b0;
    mlast[d]   = w;
    win        = w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    clear_all();
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      check_b($sformatf("rst_mem_valid_d%0d", d), o_mv[d], 1'b0);
      check_b($sformatf("rst_mem_rw_d%0d", d), o_mrw[d], 1'b0);
      check_a($sformatf("rst_mem_addr_d%0d", d), o_ma[d], '0);
      check_d($sformatf("rst_mem_wdata_d%0d", d), o_mwd[d], '0);
      check_b($sformatf("rst_grant_d%0d", d), o_gnt[d], 1'b0);
      check_quiet(d, "rst");
    end
    rst_n = 1'b1;
    tick();

    // port 0 read with offset bits set, three-cycle memory
    raise(0, 0, 1'b0, 32'h0000_1234, rnd_line());
    serve(0, 3, {16{8'hA5}}, 1'b0, w);
    check_a("p0_read_line_addr", seen_addr, 32'h0000_1230);
    check_d("p0_read_data", seen_rdata, {16{8'hA5}});
    check_b("p0_read_grant", seen_gnt, 1'b0);

    // simultaneous requests after reset, round-robin: 0 then 1, twice
    do_reset();
    for (int r = 0; r < 2; r++) begin
      raise(0, 0, 1'b0, $urandom(), rnd_line());
      raise(0, 1, 1'b0, $urandom(), rnd_line());
      serve(0, 0, rnd_line(), 1'b0, w);
      check_b($sformatf("rr_first_round%0d", r), seen_gnt, 1'b0);
      serve(0, 1, rnd_line(), 1'b0, w);
      check_b($sformatf("rr_second_round%0d", r), seen_gnt, 1'b1);
    end

    // fixed priority: port 1 keeps re-requesting and always wins
    raise(1, 0, 1'b0, $urandom(), rnd_line());
    raise(1, 1, 1'b0, $urandom(), rnd_line());
    for (int r = 0; r < 4; r++) begin
      serve(1, 0, rnd_line(), 1'b0, w);
      check_b($sformatf("prio_port1_round%0d", r), seen_gnt, 1'b1);
      if (r < 3) raise(1, 1, 1'b1, $urandom(), rnd_line());
    end
    serve(1, 2, rnd_line(), 1'b0, w);
    check_b("prio_port0_when_port1_idle", seen_gnt, 1'b0);

    // port 1 write with a ten-cycle memory stall
    raise(0, 1, 1'b1, 32'h8000_0040, {8{16'h1111}});
    serve(0, 10, rnd_line(), 1'b0, w);
    check_a("p1_write_addr", seen_addr, 32'h8000_0040);
    check_d("p1_write_rdata_zero", seen_rdata, '0);

    // port 1 arrives during port 0's memory phase and is served next
    raise(0, 0, 1'b0, $urandom(), rnd_line());
    serve(0, 4, rnd_line(), 1'b1, w);
    check_b("late_req_first_owner", seen_gnt, 1'b0);
    serve(0, 1, rnd_line(), 1'b0, w);
    check_b("late_req_second_owner", seen_gnt, 1'b1);

    // reset in the middle of a memory phase
    raise(0, 0, 1'b0, 32'h0000_2000, rnd_line());
    tick();
    check_b("pre_reset_mem_valid", o_mv[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_b("async_reset_mem_valid", o_mv[0], 1'b0);
    clear_all();
    tick();
    rst_n  = 1'b1;
    mrdy[0] = 1'b1;
    mrd[0]  = rnd_line();
    tick();
    tick();
    check_quiet(0, "stale_mem_ready");
    check_b("stale_mem_ready_mem_valid", o_mv[0], 1'b0);
    mrdy[0] = 1'b0;
    tick();
    raise(0, 0, 1'b0, 32'h0000_3008, rnd_line());
    serve(0, 2, {4{32'hDEAD_BEEF}}, 1'b0, w);
    check_a("post_reset_addr", seen_addr, 32'h0000_3000);
    check_d("post_reset_data", seen_rdata, {4{32'hDEAD_BEEF}});

    // random traffic on both instances
    for (int d = 0; d < 2; d++) begin
      do_reset();
      for (int k = 0; k < 25; k++) begin
        for (int p = 0; p < 2; p++)
          if (!pend[d][p] && $urandom_range(0, 1) == 1)
            raise(d, p, 1'($urandom_range(0, 1)), $urandom(), rnd_line());
        if (!pend[d][0] && !pend[d][1])
          raise(d, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), rnd_line());
        serve(d, int'($urandom_range(0, 4)), rnd_line(), 1'($urandom_range(0, 1)), w);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
Shares the single line-wide memory port between the I-cache controller (port 0) and the D-cache controller (port 1). Each controller drives a request with the same field layout as the cache package's memory-request struct and receives a memory-response-style result. The arbiter grants one requester at a time, holds the request in registers, and returns read data or write completion to the winner only. It sits between the two cache controllers and the memory/bus adapter.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 128, cache line width (matches cache_def::DATA_WIDTH)
OFFSET_BITS, 4, line offset bits cleared on the forwarded address
PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority to port 1 (D-cache)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
r0_valid_i  in  1  port 0 request valid, held until r0_ready_o
r0_rw_i  in  1  0 = read, 1 = write
r0_addr_i  in  ADDR_WIDTH  byte address
r0_wdata_i  in  DATA_WIDTH  write line
r0_ready_o  out  1  one-cycle completion pulse
r0_rdata_o  out  DATA_WIDTH  read line, valid when r0_ready_o
r1_valid_i, r1_rw_i, r1_addr_i, r1_wdata_i, r1_ready_o, r1_rdata_o: same as port 0, for port 1
mem_valid_o  out  1  memory request valid
mem_rw_o  out  1  memory request type
mem_addr_o  out  ADDR_WIDTH  line-aligned address
mem_wdata_o  out  DATA_WIDTH  write line
mem_ready_i  in  1  memory done; mem_rdata_i valid this cycle
mem_rdata_i  in  DATA_WIDTH  read line
grant_o  out  1  owner of the current/last transaction (debug)

Behaviour:
- FSM states: IDLE, MEM, RESP. Registers: owner, last_grant, req latch (rw/addr/wdata), rdata latch.
- Reset values: state IDLE, all outputs 0, last_grant = 1 (first RR pick is port 0), data regs 0.
- IDLE:
  - If no r*_valid_i, stay in IDLE.
  - Otherwise pick a winner. RR mode: the port other than last_grant if it is valid, else the valid one. PRIO_MODE = 1: port 1 whenever it is valid.
  - Latch the winner's rw/addr/wdata, set owner and last_grant, go to MEM.
- MEM:
  - mem_valid_o = 1; mem_rw/addr/wdata come from the latch only, never combinationally from inputs.
  - mem_addr_o = latched addr with [OFFSET_BITS-1:0] forced to 0.
  - Hold all mem outputs stable until mem_ready_i. On mem_ready_i, capture mem_rdata_i (reads only; writes capture 0) and go to RESP.
- RESP:
  - Pulse rX_ready_o for exactly one cycle for the owner only, with rX_rdata_o = captured line. Go to IDLE.
  - rX_rdata_o is 0 whenever rX_ready_o is 0.
- Latency: request sampled in IDLE at cycle N gives mem_valid_o at N+1. mem_ready_i at cycle M gives requester ready at M+1. With single-cycle memory, the minimum round trip is 3 cycles.
- Requester rule: deassert valid, or present a new request, in the cycle after ready. Because the next arbitration happens in IDLE at M+2, the ready cycle itself is never re-sampled.
- Requests arriving while in MEM/RESP wait. They are not dropped and the held inputs are not re-latched.
- Simultaneous valid in IDLE: exactly one grant per the mode. In RR mode the loser wins the next IDLE decision if it is still valid, so the wait is bounded at one transaction.
- Input changes by the non-owner during MEM have no effect. Owner input changes during MEM are ignored (a protocol violation, not checked).
- mem_ready_i outside MEM is ignored.
- Reset asserted mid-transaction: immediately return to IDLE, mem_valid_o = 0, no ready pulse. A memory response already in flight is discarded.

Decomposition:
- Import cache_def for DATA_WIDTH and for the mem_req_type/mem_data_type field layout.
- Add to cache_def: arb_state_e {ARB_IDLE, ARB_MEM, ARB_RESP} and localparam NUM_MEM_REQ = 2.
- One sub-module: arb_rr2. It is a combinational 2-way picker plus a last_grant register, and takes the PRIO_MODE parameter.

Test Plan:
- Port 0 read 0x0000_1234, memory returns 0xA5..A5 after 3 cycles → mem_addr_o = 0x0000_1230 (rw 0); r0_ready_o pulses once with 0xA5..A5; r1_ready_o stays 0.
- Both ports valid at the same cycle, RR mode, after reset → port 0 served first, then port 1; grant_o goes 0 then 1. Repeat → order 0,1 again.
- PRIO_MODE = 1: port 0 and port 1 continuously re-request → port 1 wins every IDLE decision, port 0 only when port 1 is idle.
- Port 1 write 0x8000_0040 with data 0x1111..; memory delays ready for 10 cycles → mem outputs stable for all 10 cycles; r1_ready_o pulses once at M+1 with r1_rdata_o = 0.
- Port 1 requests during port 0's MEM phase → no mem output change; port 1 is granted on the first IDLE cycle after port 0's RESP.
- rst_ni low during MEM → mem_valid_o drops asynchronously; a mem_ready_i after release produces no ready pulse; a fresh request then completes normally.
